video_blend: RTL and testbench

//  Sits directly downstream of video_mux; consumes its pixel-rate RGB, blank and sync stream.

---
 rtl/video_blend.sv | 217 +++++++++++++++++++++
 tb/tb_video_blend.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_blend.sv
`default_nettype none
// ============================================================================
//  Module      : video_blend
//  Description : Pixel-rate post-processor for the video_mux stream. It can
//                soften each pixel with the previous pixel on the same line
//                (composite-style horizontal blend) and re-times RGB, blank
//                and sync by one clock. It also counts the active pixels of
//                the most recently completed line.
//  Revision    : 1.0  initial release
// ============================================================================
module video_blend #(
    parameter int CNT_W = 10
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             pix_ce_in,
    input  logic [7:0]       red_in,
    input  logic [7:0]       green_in,
    input  logic [7:0]       blue_in,
    input  logic             hblank_in,
    input  logic             vblank_in,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic [1:0]       blend_mode,
    output logic             pix_ce,
    output logic [7:0]       red,
    output logic [7:0]       green,
    output logic [7:0]       blue,
    output logic             hblank,
    output logic             vblank,
    output logic             hsync,
    output logic             vsync,
    output logic [CNT_W-1:0] line_pixels
);

    // Line state: BLANK between lines, ACTIVE while inside a visible run.
    localparam logic [0:0] ST_BLANK  = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Blend selector values of the latched mode.
    localparam logic [1:0] MODE_HALF    = 2'd1;
    localparam logic [1:0] MODE_WEIGHT3 = 2'd2;

    logic [0:0]       state_q, state_d;
    logic [1:0]       mode_q;
    logic             vblank_prev_q;
    logic [7:0]       hist_r_q, hist_g_q, hist_b_q;
    logic [7:0]       hist_r_d, hist_g_d, hist_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] line_pixels_q, line_pixels_d;
    logic             pix_ce_q;
    logic [7:0]       red_q, green_q, blue_q;
    logic [7:0]       red_d, green_d, blue_d;
    logic             hblank_q, vblank_q, hsync_q, vsync_q;
    logic             hblank_d, vblank_d, hsync_d, vsync_d;

    logic             w_blank;
    logic             w_vblank_rise;

    assign w_blank       = hblank_in | vblank_in;
    assign w_vblank_rise = vblank_in & ~vblank_prev_q;

    // One colour channel of the two-tap blend; sums are wide enough that
    // nothing overflows before the truncating shift.
    function automatic logic [7:0] blend_chan(
        input logic [7:0] cur,
        input logic [7:0] hist,
        input logic [1:0] mode
    );
        logic [8:0] sum2;
        logic [9:0] sum4;
        sum2 = {1'b0, cur} + {1'b0, hist};
        sum4 = {2'b00, cur} + {1'b0, cur, 1'b0} + {2'b00, hist};
        case (mode)
            MODE_HALF:    blend_chan = sum2[8:1];
            MODE_WEIGHT3: blend_chan = sum4[9:2];
            default:      blend_chan = cur;
        endcase
    endfunction

    // State register for the line tracker.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= ST_BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: move between BLANK and ACTIVE only on a pixel strobe.
    always_comb begin
        state_d = state_q;
        if (pix_ce_in) begin
            case (state_q)
                ST_BLANK:  if (!w_blank) state_d = ST_ACTIVE;
                ST_ACTIVE: if (w_blank)  state_d = ST_BLANK;
                default:   state_d = ST_BLANK;
            endcase
        end
    end

    // Output/datapath decode: pass-through, blend, history and pixel count.
    always_comb begin
        red_d         = red_q;
        green_d       = green_q;
        blue_d        = blue_q;
        hblank_d      = hblank_q;
        vblank_d      = vblank_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        hist_r_d      = hist_r_q;
        hist_g_d      = hist_g_q;
        hist_b_d      = hist_b_q;
        cnt_d         = cnt_q;
        line_pixels_d = line_pixels_q;
        if (pix_ce_in) begin
            red_d    = red_in;
            green_d  = green_in;
            blue_d   = blue_in;
            hblank_d = hblank_in;
            vblank_d = vblank_in;
            hsync_d  = hsync_in;
            vsync_d  = vsync_in;
            case (state_q)
                ST_BLANK: begin
                    // First pixel of a line goes out untouched and seeds history.
                    if (!w_blank) begin
                        hist_r_d = red_in;
                        hist_g_d = green_in;
                        hist_b_d = blue_in;
                        cnt_d    = CNT_ONE;
                    end
                end
                ST_ACTIVE: begin
                    if (!w_blank) begin
                        red_d    = blend_chan(red_in,   hist_r_q, mode_q);
                        green_d  = blend_chan(green_in, hist_g_q, mode_q);
                        blue_d   = blend_chan(blue_in,  hist_b_q, mode_q);
                        hist_r_d = red_in;
                        hist_g_d = green_in;
                        hist_b_d = blue_in;
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        line_pixels_d = cnt_q;
                    end
                end
                default: begin
                    cnt_d = cnt_q;
                end
            endcase
        end
    end

    // Datapath registers; everything advances together with the strobe.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pix_ce_q      <= 1'b0;
            red_q         <= 8'd0;
            green_q       <= 8'd0;
            blue_q        <= 8'd0;
            hblank_q      <= 1'b0;
            vblank_q      <= 1'b0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            hist_r_q      <= 8'd0;
            hist_g_q      <= 8'd0;
            hist_b_q      <= 8'd0;
            cnt_q         <= '0;
            line_pixels_q <= '0;
        end else begin
            pix_ce_q      <= pix_ce_in;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
            hblank_q      <= hblank_d;
            vblank_q      <= vblank_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hist_r_q      <= hist_r_d;
            hist_g_q      <= hist_g_d;
            hist_b_q      <= hist_b_d;
            cnt_q         <= cnt_d;
            line_pixels_q <= line_pixels_d;
        end
    end

    // Blend mode is only taken at the start of vertical blank so a frame is
    // always rendered with a single mode.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            mode_q        <= 2'd0;
            vblank_prev_q <= 1'b0;
        end else if (pix_ce_in) begin
            vblank_prev_q <= vblank_in;
            if (w_vblank_rise) begin
                mode_q <= blend_mode;
            end
        end
    end

    assign pix_ce      = pix_ce_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;
    assign hblank      = hblank_q;
    assign vblank      = vblank_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_pixels = line_pixels_q;

endmodule
`default_nettype wire

// File: tb/tb_video_blend.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_blend
//  Description : Self-checking bench for video_blend. Randomised lines and
//                frames are compared cycle by cycle against a line-level
//                reference model, plus a few directed known-answer checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_video_blend;

    localparam int CNT_W   = 10;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk_sys = 1'b0;
    logic             reset = 1'b1;
    logic             pix_ce_in = 1'b0;
    logic [7:0]       red_in = 8'd0, green_in = 8'd0, blue_in = 8'd0;
    logic             hblank_in = 1'b0, vblank_in = 1'b0;
    logic             hsync_in = 1'b0, vsync_in = 1'b0;
    logic [1:0]       blend_mode = 2'd0;
    logic             pix_ce;
    logic [7:0]       red, green, blue;
    logic             hblank, vblank, hsync, vsync;
    logic [CNT_W-1:0] line_pixels;

    video_blend #(.CNT_W(CNT_W)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .pix_ce_in   (pix_ce_in),
        .red_in      (red_in),
        .green_in    (green_in),
        .blue_in     (blue_in),
        .hblank_in   (hblank_in),
        .vblank_in   (vblank_in),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .blend_mode  (blend_mode),
        .pix_ce      (pix_ce),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .hblank      (hblank),
        .vblank      (vblank),
        .hsync       (hsync),
        .vsync       (vsync),
        .line_pixels (line_pixels)
    );

    always #5 clk_sys = ~clk_sys;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a frame-level view of the stream.
    int          m_mode;
    bit          m_prev_vb;
    bit          m_in_line;
    int          m_run;
    int          m_hr, m_hg, m_hb;
    int          m_lp;
    bit          exp_ce;
    logic [23:0] exp_rgb;
    logic [3:0]  exp_flags;
    logic [1:0]  tb_bm = 2'd0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int blend_ref(input int c, input int h, input int m);
        if (m == 1) return (c + h) / 2;
        if (m == 2) return (3 * c + h) / 4;
        return c;
    endfunction

    task automatic model_reset();
        m_mode    = 0;
        m_prev_vb = 1'b0;
        m_in_line = 1'b0;
        m_run     = 0;
        m_lp      = 0;
        exp_ce    = 1'b0;
        exp_rgb   = 24'd0;
        exp_flags = 4'd0;
    endtask

    task automatic model_pixel(input int r, input int g, input int b,
                               input bit hb, input bit vb, input bit hs, input bit vs,
                               input int bm);
        int ro, go, bo;
        if (vb && !m_prev_vb) m_mode = bm;
        m_prev_vb = vb;
        ro = r; go = g; bo = b;
        if (hb || vb) begin
            if (m_in_line) m_lp = (m_run > CNT_MAX) ? CNT_MAX : m_run;
            m_in_line = 1'b0;
        end else begin
            if (m_in_line) begin
                ro = blend_ref(r, m_hr, m_mode);
                go = blend_ref(g, m_hg, m_mode);
                bo = blend_ref(b, m_hb, m_mode);
                m_run++;
            end else begin
                m_run = 1;
                m_in_line = 1'b1;
            end
            m_hr = r; m_hg = g; m_hb = b;
        end
        exp_rgb   = {8'(ro), 8'(go), 8'(bo)};
        exp_flags = {hb, vb, hs, vs};
    endtask

    task automatic check_outputs();
        check_val("pix_ce", {31'd0, pix_ce}, {31'd0, exp_ce});
        check_val("rgb", {8'd0, red, green, blue}, {8'd0, exp_rgb});
        check_val("blank_sync", {28'd0, hblank, vblank, hsync, vsync}, {28'd0, exp_flags});
        check_val("line_pixels", 32'(line_pixels), 32'(m_lp));
    endtask

    // One clock: drive inputs, advance, then compare with the model.
    task automatic step(input bit ce, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input bit hb, input bit vb, input bit hs, input bit vs);
        logic [1:0] bm;
        bm = tb_bm;
        pix_ce_in  = ce;
        red_in     = r;
        green_in   = g;
        blue_in    = b;
        hblank_in  = hb;
        vblank_in  = vb;
        hsync_in   = hs;
        vsync_in   = vs;
        blend_mode = bm;
        @(posedge clk_sys);
        #1;
        exp_ce = ce;
        if (ce) model_pixel(int'(r), int'(g), int'(b), hb, vb, hs, vs, int'(bm));
        check_outputs();
    endtask

    task automatic idle();
        step(1'b0, 8'($urandom), 8'($urandom), 8'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic px(input logic [7:0] r, input bit hb, input bit vb);
        int gap;
        step(1'b1, r, 8'($urandom), 8'($urandom), hb, vb, 1'($urandom), 1'($urandom));
        gap = $urandom_range(0, 1);
        for (int i = 0; i < gap; i++) idle();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            pix_ce_in = 1'($urandom);
            red_in    = 8'($urandom);
            hblank_in = 1'($urandom);
            vblank_in = 1'($urandom);
            @(posedge clk_sys);
            #1;
            model_reset();
            check_outputs();
        end
        reset = 1'b0;
    endtask

    // Close the current line and open a new frame with mode m latched.
    task automatic set_mode(input int m);
        tb_bm = 2'(m);
        px(8'h00, 1'b1, 1'b0);
        px(8'h00, 1'b1, 1'b1);
        px(8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        model_reset();

        // Reset and first-strobe latency.
        do_reset(3);
        check_val("reset_lp", 32'(line_pixels), 32'd0);
        idle();

        // Mode 0 pass-through.
        set_mode(0);
        px(8'h12, 1'b0, 1'b0);
        check_val("m0_r0", 32'(red), 32'h12);
        px(8'h34, 1'b0, 1'b0);
        check_val("m0_r1", 32'(red), 32'h34);

        // Mode 1 50/50.
        set_mode(1);
        px(8'h00, 1'b0, 1'b0);
        check_val("m1_r0", 32'(red), 32'h00);
        px(8'hFF, 1'b0, 1'b0);
        check_val("m1_r1", 32'(red), 32'h7F);
        px(8'h00, 1'b0, 1'b0);
        check_val("m1_r2", 32'(red), 32'h7F);

        // Mode 2 75/25, and the next line begins unblended.
        set_mode(2);
        px(8'h00, 1'b0, 1'b0);
        px(8'hFF, 1'b0, 1'b0);
        check_val("m2_r1", 32'(red), 32'hBF);
        px(8'h00, 1'b0, 1'b0);
        check_val("m2_r2", 32'(red), 32'h3F);
        px(8'h00, 1'b1, 1'b0);
        check_val("m2_lp", 32'(line_pixels), 32'd3);
        px(8'h80, 1'b0, 1'b0);
        check_val("m2_newline", 32'(red), 32'h80);

        // Line length measurement and saturation.
        px(8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 320; i++) px(8'($urandom), 1'b0, 1'b0);
        px(8'h00, 1'b1, 1'b0);
        check_val("lp_320", 32'(line_pixels), 32'd320);
        for (int i = 0; i < 1100; i++) px(8'($urandom), 1'b0, 1'b0);
        px(8'h00, 1'b1, 1'b0);
        check_val("lp_sat", 32'(line_pixels), 32'(CNT_MAX));

        // Mid-frame blend_mode change has no effect until vblank rises.
        set_mode(0);
        px(8'h00, 1'b0, 1'b0);
        tb_bm = 2'd1;
        px(8'hFF, 1'b0, 1'b0);
        check_val("midframe_hold", 32'(red), 32'hFF);
        set_mode(1);
        px(8'h00, 1'b0, 1'b0);
        px(8'hFF, 1'b0, 1'b0);
        check_val("after_vb_rise", 32'(red), 32'h7F);

        // Reset in the middle of a line.
        do_reset(2);
        check_val("midline_reset_lp", 32'(line_pixels), 32'd0);
        px(8'h40, 1'b0, 1'b0);
        check_val("restart_r", 32'(red), 32'h40);
        px(8'h41, 1'b0, 1'b0);
        px(8'h00, 1'b1, 1'b0);
        check_val("restart_lp", 32'(line_pixels), 32'd2);

        // Randomised frames: random modes, line lengths, gaps and stray
        // blend_mode changes, all checked against the model each clock.
        for (int f = 0; f < 30; f++) begin
            set_mode($urandom_range(0, 3));
            for (int l = 0; l < $urandom_range(1, 6); l++) begin
                int len;
                len = $urandom_range(1, 30);
                for (int p = 0; p < len; p++) begin
                    if ($urandom_range(0, 9) == 0) tb_bm = 2'($urandom);
                    px(8'($urandom), 1'b0, 1'b0);
                end
                for (int k = 0; k < $urandom_range(1, 3); k++) px(8'($urandom), 1'b1, 1'b0);
            end
            if ($urandom_range(0, 7) == 0) begin
                px(8'($urandom), 1'b0, 1'b0);
                do_reset($urandom_range(1, 3));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
